// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and elaboration helpers for the seven-segment BCD display.
// Segment codes are active-low, bit order g f e d c b a.
package seven_seg_pkg;

    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1011000;
    localparam logic [6:0] SEG_D8    = 7'b0000000;
    localparam logic [6:0] SEG_D9    = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} seg_state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_bcd_display_if.sv
// Request/result bundle between a value producer and the seven-segment display driver.
interface seven_seg_bcd_display_if #(
    parameter int IN_WIDTH   = 8,
    parameter int NUM_DIGITS = 3
);
    logic [IN_WIDTH-1:0]     i_value;
    logic                    i_valid;
    logic                    o_ready;
    logic [7*NUM_DIGITS-1:0] o_seven;
    logic                    o_ovf;
    logic                    o_done;

    modport master (output i_value, i_valid, input o_ready, o_seven, o_ovf, o_done);
    modport slave  (input i_value, i_valid, output o_ready, o_seven, o_ovf, o_done);
endinterface

// File: rtl/seven_seg_digit_lut.sv
// One BCD nibble to an active-low seven-segment pattern; non-decimal nibbles show a dash.
module seven_seg_digit_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seven_seg_bcd_display.sv
// Binary to NUM_DIGITS-digit seven-segment driver using an iterative double-dabble engine.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_bcd_display
    import seven_seg_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int NUM_DIGITS = 3
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    seven_seg_bcd_display_if.slave bus
);
    localparam int               BCD_W   = 4 * NUM_DIGITS;
    localparam int               CNT_W   = $clog2(IN_WIDTH + 1);
    localparam logic [31:0]      MAX_DEC = pow10(NUM_DIGITS) - 32'd1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(IN_WIDTH - 1);

    seg_state_t                   state;
    logic [IN_WIDTH-1:0]          shift_q;
    logic [BCD_W-1:0]             bcd_q;
    logic [BCD_W-1:0]             bcd_adj;
    logic [CNT_W-1:0]             cnt_q;
    logic                         ovf_q;
    logic                         ovf_out_q;
    logic                         done_q;
    logic                         ready_q;
    logic [NUM_DIGITS-1:0][6:0]   lut_seg;
    logic [NUM_DIGITS-1:0][6:0]   seg_nxt;
    logic [NUM_DIGITS-1:0][6:0]   seven_q;
    logic [NUM_DIGITS-1:0]        blank;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                                 : bcd_q[4*g +: 4];
            seven_seg_digit_lut u_lut (
                .nibble (bcd_q[4*g +: 4]),
                .seg    (lut_seg[g])
            );
        end
    endgenerate

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // A digit goes dark only if it and every digit above it are zero; the ones digit never does.
    always_comb begin
        logic all_zero;
        blank    = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            all_zero = all_zero && (bcd_q[4*k +: 4] == 4'd0);
            blank[k] = all_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // Saturation to all nines takes priority over blanking.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_nxt[k] = ovf_q    ? SEG_D9 :
                         blank[k] ? SEG_BLANK : lut_seg[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            seven_q   <= '1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        shift_q <= bus.i_value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 32'(bus.i_value) > MAX_DEC;
                        ready_q <= 1'b0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt_q            <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state <= S_LOAD;
                end
                S_LOAD: begin
                    seven_q   <= seg_nxt;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_seven = seven_q;
    assign bus.o_ovf   = ovf_out_q;
    assign bus.o_done  = done_q;

endmodule
